// File: rtl/qupls_rat_ckpt_pkg.sv
// QuplsPkg: shared register-number types plus the rename-map types used by
// the checkpointed register alias table.
package QuplsPkg;

  localparam int AREGS = 64;
  localparam int PREGS = 128;

  typedef logic [$clog2(AREGS)-1:0] aregno_t;
  typedef logic [$clog2(PREGS)-1:0] pregno_t;

  // Checkpoint index for the default 16-entry checkpoint file
  localparam int NCHK_DEFAULT = 16;
  typedef logic [$clog2(NCHK_DEFAULT)-1:0] cpno_t;

  // One complete architectural-to-physical mapping
  typedef pregno_t [AREGS-1:0] rat_map_t;

  // Reset mapping: architectural register a lives in physical register a
  function automatic rat_map_t identity_map();
    rat_map_t m;
    for (int a = 0; a < AREGS; a++) begin
      m[a] = pregno_t'(a);
    end
    return m;
  endfunction

endpackage

// File: rtl/qupls_rat_commit_map.sv
// qupls_rat_commit_map: committed architectural map. Each commit port
// returns the physical register it displaces so it can be freed; commits to
// the same areg in one cycle chain through each other in port order.
module qupls_rat_commit_map
  import QuplsPkg::*;
#(
  parameter int NCMT = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [NCMT-1:0]  cmt_v,
  input  aregno_t          cmt_a [NCMT],
  input  pregno_t          cmt_p [NCMT],
  output logic [NCMT-1:0]  free_v,
  output pregno_t          free_p [NCMT]
);

  rat_map_t com_r;
  rat_map_t com_next_s;
  pregno_t  prior_s [NCMT];

  // Displaced mapping per port: youngest lower port to the same areg, else the committed map
  always_comb begin
    for (int i = 0; i < NCMT; i++) begin
      prior_s[i] = com_r[cmt_a[i]];
      for (int j = 0; j < i; j++) begin
        prior_s[i] = (cmt_v[j] && (cmt_a[j] == cmt_a[i])) ? cmt_p[j] : prior_s[i];
      end
    end
  end

  // Next committed map: ports applied in order so the highest port wins
  always_comb begin
    com_next_s = com_r;
    for (int i = 0; i < NCMT; i++) begin
      com_next_s[cmt_a[i]] = cmt_v[i] ? cmt_p[i] : com_next_s[cmt_a[i]];
    end
  end

  // Committed map and registered free outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      com_r  <= identity_map();
      free_v <= {NCMT{1'b0}};
      for (int i = 0; i < NCMT; i++) begin
        free_p[i] <= pregno_t'(0);
      end
    end else begin
      com_r  <= com_next_s;
      free_v <= cmt_v;
      for (int i = 0; i < NCMT; i++) begin
        free_p[i] <= prior_s[i];
      end
    end
  end

endmodule

// File: rtl/qupls_rat_ckpt.sv
// qupls_rat_ckpt: speculative register alias table with a circular file of
// branch checkpoints, physical-register ready bits and a committed map.
// Build option: define QUPLS_RAT_BYPASS_EN to forward same-cycle accepted
// rename writes to the read ports (forwarded registers read as not ready).
module qupls_rat_ckpt
  import QuplsPkg::*;
#(
  parameter int NRD   = 16,
  parameter int NWR   = 4,
  parameter int NCMT  = 4,
  parameter int NCHK  = 16,
  parameter int CPBIT = $clog2(NCHK)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              nq,
  input  logic [NWR-1:0]    wr_v,
  input  aregno_t           wr_a [NWR],
  input  pregno_t           wr_p [NWR],
  input  logic              qbr,
  output logic              stallq,
  output logic [CPBIT-1:0]  cp_o,
  input  aregno_t           rd_a [NRD],
  output pregno_t           rd_p [NRD],
  output logic [NRD-1:0]    rd_v,
  input  logic [NWR-1:0]    wb_v,
  input  pregno_t           wb_p [NWR],
  input  logic [NCMT-1:0]   cmt_v,
  input  aregno_t           cmt_a [NCMT],
  input  pregno_t           cmt_p [NCMT],
  input  logic              cmt_br,
  input  logic              restore,
  input  logic [CPBIT-1:0]  restore_cp,
  output logic [NCMT-1:0]   free_v,
  output pregno_t           free_p [NCMT]
);

  localparam logic [CPBIT:0] CNT_FULL = (CPBIT+1)'(NCHK);

  rat_map_t          cur_r;
  rat_map_t          cur_next_s;
  rat_map_t          ckpt_r [NCHK];
  logic [PREGS-1:0]  ready_r;
  logic [PREGS-1:0]  ready_next_s;
  logic [CPBIT-1:0]  head_r;
  logic [CPBIT-1:0]  tail_r;
  logic [CPBIT:0]    count_r;
  logic [CPBIT:0]    count_next_s;
  logic [CPBIT-1:0]  restore_span_s;
  logic [CPBIT:0]    restore_count_s;
  logic              accept_s;
  logic              alloc_s;
  logic              release_s;

  // A branch group needs a free checkpoint; a restore squashes whatever is being enqueued
  assign stallq    = qbr & (count_r == CNT_FULL);
  assign accept_s  = nq & ~stallq & ~restore;
  assign alloc_s   = accept_s & qbr;
  assign release_s = cmt_br & (count_r != (CPBIT+1)'(0));
  assign cp_o      = tail_r;

  // Group rename writes (highest port wins) and ready bits (allocation clear beats writeback)
  always_comb begin
    cur_next_s   = cur_r;
    ready_next_s = ready_r;
    for (int i = 0; i < NWR; i++) begin
      ready_next_s[wb_p[i]] = wb_v[i] ? 1'b1 : ready_next_s[wb_p[i]];
    end
    for (int i = 0; i < NWR; i++) begin
      cur_next_s[wr_a[i]]   = (accept_s && wr_v[i]) ? wr_p[i] : cur_next_s[wr_a[i]];
      ready_next_s[wr_p[i]] = (accept_s && wr_v[i]) ? 1'b0 : ready_next_s[wr_p[i]];
    end
  end

  // Checkpoint occupancy: after a restore, everything from head up to restore_cp survives
  always_comb begin
    restore_span_s  = restore_cp - head_r + CPBIT'(1);
    restore_count_s = ((restore_span_s == CPBIT'(0)) ? CNT_FULL : {1'b0, restore_span_s})
                      - (CPBIT+1)'(release_s);
    count_next_s    = count_r + (CPBIT+1)'(alloc_s) - (CPBIT+1)'(release_s);
  end

  // Read ports look up the speculative map and ready bits
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_p[k] = cur_r[rd_a[k]];
      rd_v[k] = ready_r[cur_r[rd_a[k]]];
`ifdef QUPLS_RAT_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (accept_s && wr_v[i] && (wr_a[i] == rd_a[k])) begin
          rd_p[k] = wr_p[i];
          rd_v[k] = 1'b0;
        end else begin
          rd_p[k] = rd_p[k];
          rd_v[k] = rd_v[k];
        end
      end
`endif
    end
  end

  // Speculative map, ready bits and checkpoint ring pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r   <= identity_map();
      ready_r <= {PREGS{1'b1}};
      head_r  <= CPBIT'(0);
      tail_r  <= CPBIT'(0);
      count_r <= (CPBIT+1)'(0);
    end else begin
      ready_r <= ready_next_s;
      head_r  <= head_r + CPBIT'(release_s);
      if (restore) begin
        cur_r   <= ckpt_r[restore_cp];
        tail_r  <= restore_cp + CPBIT'(1);
        count_r <= restore_count_s;
      end else begin
        cur_r   <= cur_next_s;
        tail_r  <= tail_r + CPBIT'(alloc_s);
        count_r <= count_next_s;
      end
    end
  end

  // Snapshot the map including this group's writes into the newly allocated checkpoint
  always_ff @(posedge clk) begin
    if (!rst && alloc_s) begin
      ckpt_r[tail_r] <= cur_next_s;
    end
  end

  qupls_rat_commit_map #(
    .NCMT (NCMT)
  ) u_commit_map (
    .clk    (clk),
    .rst    (rst),
    .cmt_v  (cmt_v),
    .cmt_a  (cmt_a),
    .cmt_p  (cmt_p),
    .free_v (free_v),
    .free_p (free_p)
  );

endmodule
